id_ex_stage: RTL and testbench

// - ID->EX pipeline stage of the 5-stage MIPS core.
// - Consumes the forward-select codes produced in ID, builds the final A/B operands from
//   RF read data or EX/MEM/WB bypass data, and registers them with control into the EX stage.
// - Owns load-use hazard detection: bubble insertion and ID/IF freeze.
// - Also handles branch flush, downstream hold, and a stall performance counter.

---
 rtl/core_pkg.sv | 11 +
 rtl/id_ex_stage_if.sv | 53 +++++
 rtl/operand_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core constants: forward-select encodings and the default datapath width.
package core_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX stage bundle: ID-side operands/control in, registered EX-side state out.
interface id_ex_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned CNT_W  = 32
);
   logic              id_valid;
   logic [4:0]        id_rs_addr;
   logic [4:0]        id_rt_addr;
   logic              id_rs_used;
   logic              id_rt_used;
   logic [DATA_W-1:0] rf_rdata0;
   logic [DATA_W-1:0] rf_rdata1;
   logic [1:0]        sel_rf_a;
   logic [1:0]        sel_rf_b;
   logic [DATA_W-1:0] fwd_ex_data;
   logic [DATA_W-1:0] fwd_mem_data;
   logic [DATA_W-1:0] fwd_wb_data;
   logic [DATA_W-1:0] id_imm;
   logic [CTRL_W-1:0] id_ctrl;
   logic [4:0]        id_waddr;
   logic              id_wen;
   logic              id_mem_read;
   logic              flush;
   logic              hold;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_op_a;
   logic [DATA_W-1:0] ex_op_b;
   logic [DATA_W-1:0] ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [4:0]        ex_waddr;
   logic              ex_wen;
   logic              ex_mem_read;
   logic              stall_id;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, rf_rdata0, rf_rdata1,
             sel_rf_a, sel_rf_b, fwd_ex_data, fwd_mem_data, fwd_wb_data, id_imm, id_ctrl,
             id_waddr, id_wen, id_mem_read, flush, hold,
      input  ex_valid, ex_op_a, ex_op_b, ex_imm, ex_ctrl, ex_waddr, ex_wen, ex_mem_read,
             stall_id, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, rf_rdata0, rf_rdata1,
             sel_rf_a, sel_rf_b, fwd_ex_data, fwd_mem_data, fwd_wb_data, id_imm, id_ctrl,
             id_waddr, id_wen, id_mem_read, flush, hold,
      output ex_valid, ex_op_a, ex_op_b, ex_imm, ex_ctrl, ex_waddr, ex_wen, ex_mem_read,
             stall_id, stall_cnt
   );

endinterface

// File: rtl/operand_mux.sv
// 4:1 operand select (RF / EX / MEM / WB bypass); register $0 always reads as zero.
module operand_mux
   import core_pkg::*;
#(
   parameter int unsigned WIDTH = core_pkg::DATA_W
) (
   input  logic [1:0]       sel,
   input  logic [4:0]       addr,
   input  logic [WIDTH-1:0] rf_data,
   input  logic [WIDTH-1:0] ex_data,
   input  logic [WIDTH-1:0] mem_data,
   input  logic [WIDTH-1:0] wb_data,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      if (addr != 5'd0) begin
         unique case (sel)
            FWD_RF:  result = rf_data;
            FWD_EX:  result = ex_data;
            FWD_MEM: result = mem_data;
            FWD_WB:  result = wb_data;
            default: result = '0;
         endcase
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand bypass, load-use bubble insertion, flush/hold control
// and a bubble counter.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int unsigned DATA_W = core_pkg::DATA_W,
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned CNT_W  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   id_ex_stage_if.slave bus
);

   logic [DATA_W-1:0] op_a, op_b;
   logic              lu;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [4:0]        waddr_q, waddr_d;
   logic              wen_q, wen_d;
   logic              mem_read_q, mem_read_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   operand_mux #(.WIDTH(DATA_W)) u_mux_a (
      .sel      (bus.sel_rf_a),
      .addr     (bus.id_rs_addr),
      .rf_data  (bus.rf_rdata0),
      .ex_data  (bus.fwd_ex_data),
      .mem_data (bus.fwd_mem_data),
      .wb_data  (bus.fwd_wb_data),
      .result   (op_a)
   );

   operand_mux #(.WIDTH(DATA_W)) u_mux_b (
      .sel      (bus.sel_rf_b),
      .addr     (bus.id_rt_addr),
      .rf_data  (bus.rf_rdata1),
      .ex_data  (bus.fwd_ex_data),
      .mem_data (bus.fwd_mem_data),
      .wb_data  (bus.fwd_wb_data),
      .result   (op_b)
   );

   // A load in EX has no bypassable result yet; its consumer must wait for MEM.
   always_comb begin
      lu = valid_q & mem_read_q & wen_q & bus.id_valid & (waddr_q != 5'd0) &
           ((bus.id_rs_used & (bus.id_rs_addr == waddr_q)) |
            (bus.id_rt_used & (bus.id_rt_addr == waddr_q)));
   end

   always_comb begin
      valid_d    = valid_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      imm_d      = imm_q;
      ctrl_d     = ctrl_q;
      waddr_d    = waddr_q;
      wen_d      = wen_q;
      mem_read_d = mem_read_q;
      cnt_d      = cnt_q;
      if (bus.flush) begin
         valid_d    = 1'b0;
         wen_d      = 1'b0;
         mem_read_d = 1'b0;
      end else if (bus.hold) begin
         // everything holds, including a pending bubble
      end else if (lu) begin
         valid_d    = 1'b0;
         wen_d      = 1'b0;
         mem_read_d = 1'b0;
         cnt_d      = cnt_q + CNT_W'(1);
      end else begin
         valid_d    = bus.id_valid;
         op_a_d     = op_a;
         op_b_d     = op_b;
         imm_d      = bus.id_imm;
         ctrl_d     = bus.id_ctrl;
         waddr_d    = bus.id_waddr;
         wen_d      = bus.id_wen & bus.id_valid;
         mem_read_d = bus.id_mem_read & bus.id_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         imm_q      <= '0;
         ctrl_q     <= '0;
         waddr_q    <= '0;
         wen_q      <= 1'b0;
         mem_read_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         imm_q      <= imm_d;
         ctrl_q     <= ctrl_d;
         waddr_q    <= waddr_d;
         wen_q      <= wen_d;
         mem_read_q <= mem_read_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.stall_id    = bus.hold | (lu & ~bus.flush);
   assign bus.ex_valid    = valid_q;
   assign bus.ex_op_a     = op_a_q;
   assign bus.ex_op_b     = op_b_q;
   assign bus.ex_imm      = imm_q;
   assign bus.ex_ctrl     = ctrl_q;
   assign bus.ex_waddr    = waddr_q;
   assign bus.ex_wen      = wen_q;
   assign bus.ex_mem_read = mem_read_q;
   assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass select, load-use bubble, flush, hold and async reset.
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0;
      bus.id_rs_used = 0; bus.id_rt_used = 0;
      bus.rf_rdata0 = 0; bus.rf_rdata1 = 0; bus.sel_rf_a = 0; bus.sel_rf_b = 0;
      bus.fwd_ex_data = 0; bus.fwd_mem_data = 0; bus.fwd_wb_data = 0;
      bus.id_imm = 0; bus.id_ctrl = 0; bus.id_waddr = 0; bus.id_wen = 0;
      bus.id_mem_read = 0; bus.flush = 0; bus.hold = 0;
   endtask

   // Present one instruction in ID (sel defaults to RF).
   task automatic present(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt,
                          input logic rt_u, input logic [4:0] wa, input logic ld,
                          input logic [31:0] a, input logic [31:0] b);
      bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rs_used = rs_u;
      bus.id_rt_addr = rt; bus.id_rt_used = rt_u; bus.id_waddr = wa; bus.id_wen = 1;
      bus.id_mem_read = ld; bus.rf_rdata0 = a; bus.rf_rdata1 = b;
      bus.sel_rf_a = 2'b00; bus.sel_rf_b = 2'b00;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      #2;
      check("rst_valid", 64'(bus.ex_valid), 64'd0);
      check("rst_cnt", 64'(bus.stall_cnt), 64'd0);
      check("rst_stall", 64'(bus.stall_id), 64'd0);
      check("rst_opa", 64'(bus.ex_op_a), 64'd0);
      #10 rst_n = 1'b1;
      step();

      // plain RF pass-through
      present(5'd1, 1, 5'd2, 1, 5'd3, 0, 32'h11, 32'h22);
      bus.id_imm = 32'h1234; bus.id_ctrl = 16'hBEEF;
      step();
      check("plain_opa", 64'(bus.ex_op_a), 64'h11);
      check("plain_opb", 64'(bus.ex_op_b), 64'h22);
      check("plain_valid", 64'(bus.ex_valid), 64'd1);
      check("plain_imm", 64'(bus.ex_imm), 64'h1234);
      check("plain_ctrl", 64'(bus.ex_ctrl), 64'hBEEF);
      check("plain_waddr", 64'(bus.ex_waddr), 64'd3);
      check("plain_wen", 64'(bus.ex_wen), 64'd1);

      // bypass from EX and WB, then MEM
      bus.fwd_ex_data = 32'hAA; bus.fwd_mem_data = 32'hBB; bus.fwd_wb_data = 32'hCC;
      bus.sel_rf_a = 2'b01; bus.sel_rf_b = 2'b11;
      step();
      check("byp_opa_ex", 64'(bus.ex_op_a), 64'hAA);
      check("byp_opb_wb", 64'(bus.ex_op_b), 64'hCC);
      bus.id_rs_addr = 5'd0; bus.sel_rf_b = 2'b10;
      step();
      check("byp_opa_zero", 64'(bus.ex_op_a), 64'd0);
      check("byp_opb_mem", 64'(bus.ex_op_b), 64'hBB);

      // load-use: lw $5 then add reading $5
      present(5'd1, 1, 5'd0, 0, 5'd5, 1, 32'h10, 32'h0);
      step();
      check("lu_ld_memrd", 64'(bus.ex_mem_read), 64'd1);
      present(5'd5, 1, 5'd6, 1, 5'd7, 0, 32'hDEAD, 32'h66);
      bus.sel_rf_a = 2'b01;
      #1 check("lu_stall", 64'(bus.stall_id), 64'd1);
      step();
      check("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
      check("lu_bubble_wen", 64'(bus.ex_wen), 64'd0);
      check("lu_cnt", 64'(bus.stall_cnt), 64'd1);
      check("lu_stall_drop", 64'(bus.stall_id), 64'd0);
      bus.sel_rf_a = 2'b10; bus.fwd_mem_data = 32'h55;
      step();
      check("lu_opa_mem", 64'(bus.ex_op_a), 64'h55);
      check("lu_valid", 64'(bus.ex_valid), 64'd1);
      check("lu_waddr", 64'(bus.ex_waddr), 64'd7);
      check("lu_cnt_once", 64'(bus.stall_cnt), 64'd1);

      // flush during load-use
      present(5'd1, 1, 5'd0, 0, 5'd8, 1, 32'h1, 32'h0);
      step();
      present(5'd0, 0, 5'd8, 1, 5'd9, 0, 32'h0, 32'h2);
      #1 check("fl_lu_stall", 64'(bus.stall_id), 64'd1);
      bus.flush = 1;
      #1 check("fl_stall", 64'(bus.stall_id), 64'd0);
      step();
      bus.flush = 0;
      check("fl_valid", 64'(bus.ex_valid), 64'd0);
      check("fl_wen", 64'(bus.ex_wen), 64'd0);
      check("fl_memrd", 64'(bus.ex_mem_read), 64'd0);
      check("fl_cnt", 64'(bus.stall_cnt), 64'd1);

      // hold 3 cycles with lu true, then exactly one bubble
      present(5'd1, 1, 5'd0, 0, 5'd9, 1, 32'h99, 32'h0);
      step();
      present(5'd9, 1, 5'd0, 0, 5'd10, 0, 32'h77, 32'h0);
      bus.hold = 1;
      for (int i = 0; i < 3; i++) begin
         #1 check("hd_stall", 64'(bus.stall_id), 64'd1);
         step();
         check("hd_valid", 64'(bus.ex_valid), 64'd1);
         check("hd_opa", 64'(bus.ex_op_a), 64'h99);
         check("hd_waddr", 64'(bus.ex_waddr), 64'd9);
         check("hd_memrd", 64'(bus.ex_mem_read), 64'd1);
         check("hd_cnt", 64'(bus.stall_cnt), 64'd1);
      end
      bus.hold = 0;
      #1 check("hd_rel_stall", 64'(bus.stall_id), 64'd1);
      step();
      check("hd_bubble_valid", 64'(bus.ex_valid), 64'd0);
      check("hd_bubble_cnt", 64'(bus.stall_cnt), 64'd2);
      bus.sel_rf_a = 2'b10; bus.fwd_mem_data = 32'h66;
      step();
      check("hd_opa_mem", 64'(bus.ex_op_a), 64'h66);
      check("hd_valid2", 64'(bus.ex_valid), 64'd1);
      check("hd_cnt_once", 64'(bus.stall_cnt), 64'd2);

      // async reset while a stall is pending
      present(5'd1, 1, 5'd0, 0, 5'd11, 1, 32'h3, 32'h0);
      step();
      present(5'd11, 1, 5'd0, 0, 5'd12, 0, 32'h44, 32'h0);
      #1 check("rs_pre_stall", 64'(bus.stall_id), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rs_valid", 64'(bus.ex_valid), 64'd0);
      check("rs_wen", 64'(bus.ex_wen), 64'd0);
      check("rs_cnt", 64'(bus.stall_cnt), 64'd0);
      check("rs_stall", 64'(bus.stall_id), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rs_restart_valid", 64'(bus.ex_valid), 64'd1);
      check("rs_restart_opa", 64'(bus.ex_op_a), 64'h44);
      check("rs_restart_cnt", 64'(bus.stall_cnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
